// File: rtl/switch_debounce_sync_pkg.sv
// Shared board constants and debounce FSM state encoding for switch-driven blocks.
// The encodings are fixed so the state can be read directly off the debug port.
package switch_debounce_sync_pkg;

  localparam int CLK_FREQ_HZ             = 100_000_000;
  localparam int DEBOUNCE_MS_DEFAULT     = 10;
  localparam int DEBOUNCE_CYCLES_DEFAULT = (CLK_FREQ_HZ / 1000) * DEBOUNCE_MS_DEFAULT;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'b00,
    WAIT_HIGH   = 2'b01,
    STABLE_HIGH = 2'b11,
    WAIT_LOW    = 2'b10
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser bringing an asynchronous level into the I_P_CLK domain.
// Both flops clear on reset so the first synchronised value after release is 0.
module sync_2ff (
  input  logic I_P_CLK,
  input  logic I_P_RST,
  input  logic I_P_ASYNC,
  output logic O_P_SYNC
);

  logic s1;
  logic s2;

  always_ff @(posedge I_P_CLK or posedge I_P_RST) begin
    if (I_P_RST) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= I_P_ASYNC;
      s2 <= s1;
    end
  end

  assign O_P_SYNC = s2;

endmodule

// File: rtl/switch_debounce_sync.sv
// Debounces one raw board switch: synchronise, then require DEBOUNCE_CYCLES of a
// steady new level before committing it, with one-cycle rise/fall pulses on commit.
module switch_debounce_sync
  import switch_debounce_sync_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic   I_P_CLK,
  input  logic   I_P_RST,
  input  logic   I_P_SW,
  output logic   O_P_DB,
  output logic   O_P_RISE,
  output logic   O_P_FALL,
  output logic   O_P_LED_BUSY,
  output state_t O_P_STATE
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic           sw_s2;
  state_t         state;
  state_t         state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic           db;
  logic           db_nxt;
  logic           rise;
  logic           rise_nxt;
  logic           fall;
  logic           fall_nxt;
  logic           busy;
  logic           busy_nxt;

  sync_2ff u_sync (
    .I_P_CLK   (I_P_CLK),
    .I_P_RST   (I_P_RST),
    .I_P_ASYNC (I_P_SW),
    .O_P_SYNC  (sw_s2)
  );

  always_ff @(posedge I_P_CLK or posedge I_P_RST) begin
    if (I_P_RST) begin
      state <= STABLE_LOW;
      cnt   <= '0;
      db    <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      db    <= db_nxt;
      rise  <= rise_nxt;
      fall  <= fall_nxt;
      busy  <= busy_nxt;
    end
  end

  // Any disagreement while waiting drops back to the stable state with a clean count.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    db_nxt    = db;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      STABLE_LOW: begin
        if (sw_s2) begin
          state_nxt = WAIT_HIGH;
          cnt_nxt   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!sw_s2) begin
          state_nxt = STABLE_LOW;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = STABLE_HIGH;
          cnt_nxt   = '0;
          db_nxt    = 1'b1;
          rise_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      STABLE_HIGH: begin
        if (!sw_s2) begin
          state_nxt = WAIT_LOW;
          cnt_nxt   = '0;
        end
      end
      WAIT_LOW: begin
        if (sw_s2) begin
          state_nxt = STABLE_HIGH;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = STABLE_LOW;
          cnt_nxt   = '0;
          db_nxt    = 1'b0;
          fall_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = STABLE_LOW;
        cnt_nxt   = '0;
        db_nxt    = 1'b0;
      end
    endcase
    busy_nxt = (state_nxt == WAIT_HIGH) || (state_nxt == WAIT_LOW);
  end

  assign O_P_DB       = db;
  assign O_P_RISE     = rise;
  assign O_P_FALL     = fall;
  assign O_P_LED_BUSY = busy;
  assign O_P_STATE    = state;

endmodule

// File: tb/tb_switch_debounce_sync.sv
// Directed bench for switch_debounce_sync: one instance at DEBOUNCE_CYCLES=4 and
// one at DEBOUNCE_CYCLES=2, edge-by-edge expectations counted from edge 0.
module tb_switch_debounce_sync;
  import switch_debounce_sync_pkg::*;

  logic   clk = 1'b0;
  logic   rst = 1'b0;
  logic   sw = 1'b0;
  logic   rst2 = 1'b0;
  logic   sw2 = 1'b0;
  logic   db, rise, fall, busy;
  logic   db2, rise2, fall2, busy2;
  state_t st, st2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  switch_debounce_sync #(.DEBOUNCE_CYCLES(4)) dut (
    .I_P_CLK      (clk),
    .I_P_RST      (rst),
    .I_P_SW       (sw),
    .O_P_DB       (db),
    .O_P_RISE     (rise),
    .O_P_FALL     (fall),
    .O_P_LED_BUSY (busy),
    .O_P_STATE    (st)
  );

  switch_debounce_sync #(.DEBOUNCE_CYCLES(2)) dut2 (
    .I_P_CLK      (clk),
    .I_P_RST      (rst2),
    .I_P_SW       (sw2),
    .O_P_DB       (db2),
    .O_P_RISE     (rise2),
    .O_P_FALL     (fall2),
    .O_P_LED_BUSY (busy2),
    .O_P_STATE    (st2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_db"},   {31'd0, db},   32'd0);
    chk({tag, "_rise"}, {31'd0, rise}, 32'd0);
    chk({tag, "_fall"}, {31'd0, fall}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  int pat [12] = '{1, 1, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0};
  int n_rise;
  int n_fall;
  int n_busy;

  initial begin
    // Case 1: reset asserted with the switch high, before any clock edge.
    #2;
    sw   = 1'b1;
    rst  = 1'b1;
    rst2 = 1'b1;
    #1;
    chk_outs_zero("t1_async");
    chk("t1_state", {30'd0, st}, {30'd0, STABLE_LOW});
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_outs_zero($sformatf("t1_held%0d", i));
    end
    rst  = 1'b0;
    rst2 = 1'b0;
    sw   = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("t1_idle_state", {30'd0, st}, {30'd0, STABLE_LOW});

    // Case 2: clean 0->1 held.
    sw = 1'b1;
    for (int e = 0; e < 8; e++) begin
      tick();
      chk($sformatf("t2_db_e%0d", e),   {31'd0, db},   {31'd0, e >= 6});
      chk($sformatf("t2_rise_e%0d", e), {31'd0, rise}, {31'd0, e == 6});
      chk($sformatf("t2_fall_e%0d", e), {31'd0, fall}, 32'd0);
      chk($sformatf("t2_busy_e%0d", e), {31'd0, busy}, {31'd0, (e >= 2) && (e <= 5)});
    end
    chk("t2_state", {30'd0, st}, {30'd0, STABLE_HIGH});

    // Case 4: from stable high, clean 1->0 held.
    sw = 1'b0;
    for (int e = 0; e < 8; e++) begin
      tick();
      chk($sformatf("t4_db_e%0d", e),   {31'd0, db},   {31'd0, e < 6});
      chk($sformatf("t4_fall_e%0d", e), {31'd0, fall}, {31'd0, e == 6});
      chk($sformatf("t4_rise_e%0d", e), {31'd0, rise}, 32'd0);
      chk($sformatf("t4_busy_e%0d", e), {31'd0, busy}, {31'd0, (e >= 2) && (e <= 5)});
    end

    // Case 3: bounce (3 high, 1 low, 3 high, low) never commits.
    for (int e = 0; e < 12; e++) begin
      sw = pat[e][0];
      tick();
      chk($sformatf("t3_db_e%0d", e),   {31'd0, db},   32'd0);
      chk($sformatf("t3_rise_e%0d", e), {31'd0, rise}, 32'd0);
    end
    chk("t3_state", {30'd0, st}, {30'd0, STABLE_LOW});
    chk("t3_busy",  {31'd0, busy}, 32'd0);

    // Case 5: reset in WAIT_HIGH with cnt=2, switch kept high.
    sw = 1'b1;
    for (int e = 0; e < 5; e++) tick();
    chk("t5_pre_state", {30'd0, st}, {30'd0, WAIT_HIGH});
    chk("t5_pre_busy",  {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk_outs_zero("t5_async");
    chk("t5_rst_state", {30'd0, st}, {30'd0, STABLE_LOW});
    tick();
    chk_outs_zero("t5_held");
    rst = 1'b0;
    for (int e = 0; e < 8; e++) begin
      tick();
      chk($sformatf("t5_db_e%0d", e),   {31'd0, db},   {31'd0, e >= 6});
      chk($sformatf("t5_rise_e%0d", e), {31'd0, rise}, {31'd0, e == 6});
    end

    // Case 6a: level held equal to stable state produces nothing.
    n_rise = 0;
    n_fall = 0;
    n_busy = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (rise) n_rise++;
      if (fall) n_fall++;
      if (busy) n_busy++;
    end
    chk("t6_hold_rise", n_rise, 0);
    chk("t6_hold_fall", n_fall, 0);
    chk("t6_hold_busy", n_busy, 0);
    chk("t6_hold_db",   {31'd0, db}, 32'd1);

    // Case 6b: DEBOUNCE_CYCLES=2 commits at edge 4, exactly one rise.
    sw2    = 1'b1;
    n_rise = 0;
    for (int e = 0; e < 6; e++) begin
      tick();
      if (rise2) n_rise++;
      chk($sformatf("t6_db2_e%0d", e),   {31'd0, db2},   {31'd0, e >= 4});
      chk($sformatf("t6_rise2_e%0d", e), {31'd0, rise2}, {31'd0, e == 4});
      chk($sformatf("t6_busy2_e%0d", e), {31'd0, busy2}, {31'd0, (e >= 2) && (e <= 3)});
    end
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (rise2) n_rise++;
    end
    chk("t6_rise2_count", n_rise, 1);
    chk("t6_fall2", {31'd0, fall2}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
